alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Sits directly downstream of the PB3 binary-op ALU ROMs. Waits for the
//  result to settle, then latches Y, FV and FLTADD#. It drives the result
//  onto the internal bus and pulses the AC write strobe. It also owns the
//  L (link) and V (overflow) flag registers.
//  Gives the processor board one clean, clocked write-back per ALU operation.
// PARAMETERS
//  WIDTH   16  datapath width of ALU result and bus
//  SETTLE  2   clocks to wait after start for ROM carry chain to settle (0 legal)
// PORTS
//  clk          in   1      board clock; all state changes on rising edge
//  nreset       in   1      reset, synchronous, active-high
//  start        in   1      ALU op issued, operands stable; sampled in IDLE only
//  y_in         in   WIDTH  ALU result (Y)
//  fv_in        in   1      ALU overflow output
//  nfltadd_in   in   1      ALU flip-L request, active low
//  l_load       in   1      direct load of L from l_data
//  l_data       in   1      value for l_load
//  v_clr        in   1      clear V flag
//  ibus_out     out  WIDTH  latched result to internal bus
//  ibus_oe      out  1      bus drive enable
//  ac_we        out  1      one-clock AC write strobe
//  fl           out  1      L flag register
//  fv           out  1      V flag register (sticky)
//  busy         out  1      high whenever state != IDLE
//  done         out  1      one-clock pulse, coincident with ac_we
// BEHAVIOUR
//  Reset: on a clock edge with nreset=1:
//   - state=IDLE; settle count=0
//   - ibus_out=0, ibus_oe=0, ac_we=0, done=0, busy=0, fl=0, fv=0
//   - reset overrides everything, including mid-operation; the aborted op
//     never writes AC
//  States: IDLE -> WAIT -> CAPTURE -> DRIVE -> WRITE -> IDLE.
//   - IDLE: start=1 at edge k -> WAIT (SETTLE>0) or CAPTURE (SETTLE=0);
//     busy=1 from k.
//   - WAIT: counts SETTLE cycles, then -> CAPTURE.
//   - CAPTURE: at the exiting edge, result reg<=y_in and flags are updated.
//     ibus_oe=0.
//   - DRIVE: ibus_oe=1, ibus_out=result, ac_we=0 (bus setup cycle).
//   - WRITE: ibus_oe=1, ac_we=1, done=1; next edge -> IDLE.
//   - Latency: ac_we is high in the clock cycle after edge k+SETTLE+2. The
//     op occupies SETTLE+3 cycles.
//  Result reg: holds its value until the next CAPTURE. ibus_out shows it
//  whenever not in reset.
//  Flag update at the CAPTURE edge:
//   - nfltadd_in=0 toggles L.
//   - fv_in=1 sets V.
//  Flag ops at other edges:
//   - l_load is honoured in any state: fl<=l_data.
//   - Same edge as CAPTURE with l_load=1: fl<=l_data ^ ~nfltadd_in.
//   - v_clr is honoured in any state. Same edge as CAPTURE with fv_in=1:
//     set wins, fv=1.
//  start while busy: ignored, not queued. start at the WRITE->IDLE edge is
//  also ignored; it is first seen in IDLE.
//  X on y_in outside CAPTURE has no effect.
// TESTING
//  1. SETTLE=2, y_in=16'hDEAD, nfltadd_in=1, fv_in=0, start at edge 0:
//     ac_we=1 only in the cycle after edge 4; ibus_out=DEAD; fl, fv unchanged.
//  2. fl=0; two ops with nfltadd_in=0 at CAPTURE: fl=1 after the first,
//     0 after the second.
//  3. Op with fv_in=1: fv=1; next op with fv_in=0: fv stays 1.
//     v_clr pulse: fv=0. v_clr together with fv_in=1 at CAPTURE: fv=1.
//  4. start held high for 10 cycles: exactly one ac_we pulse per
//     SETTLE+3-cycle op, no back-to-back overlap; busy never drops mid-op.
//  5. nreset=1 during DRIVE: next cycle all outputs 0 and state IDLE;
//     no ac_we pulse follows.
//  6. l_load=1, l_data=1, nfltadd_in=0 on the CAPTURE edge: fl=0.
//     Sweep SETTLE=0: ac_we in the cycle after edge 2.

Source files
------------

// File: rtl/alu_result_stage.sv
// Write-back stage behind the binary-op ALU ROMs. It waits for the ROM outputs to settle and latches the result,
// then drives the bus and strobes the AC write. It also owns the L (link) and V (overflow) flags.
module alu_result_stage #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic [WIDTH-1:0] y_in,
  input  logic             fv_in,
  input  logic             nfltadd_in,
  input  logic             l_load,
  input  logic             l_data,
  input  logic             v_clr,
  output logic [WIDTH-1:0] ibus_out,
  output logic             ibus_oe,
  output logic             ac_we,
  output logic             fl,
  output logic             fv,
  output logic             busy,
  output logic             done
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    CAPTURE = 3'd2,
    DRIVE   = 3'd3,
    WRITE   = 3'd4
  } state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] result_reg;
  logic             capture;
  logic             flip;

  assign capture  = (state_reg == CAPTURE);
  assign flip     = capture & ~nfltadd_in;
  assign ibus_out = result_reg;

  always_ff @(posedge clk) begin
    // Strobes default low so they stay single-cycle.
    ac_we <= 1'b0;
    done  <= 1'b0;
    if (nreset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      result_reg <= '0;
      ibus_oe    <= 1'b0;
      busy       <= 1'b0;
      fl         <= 1'b0;
      fv         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= (SETTLE == 0) ? CAPTURE : WAIT;
            cnt_reg   <= '0;
            busy      <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_reg == LAST) begin
            state_reg <= CAPTURE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        CAPTURE: begin
          state_reg  <= DRIVE;
          result_reg <= y_in;
          ibus_oe    <= 1'b1;
        end
        DRIVE: begin
          state_reg <= WRITE;
          ac_we     <= 1'b1;
          done      <= 1'b1;
        end
        WRITE: begin
          // start on this edge is deliberately dropped; it is first seen in IDLE.
          state_reg <= IDLE;
          ibus_oe   <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          ibus_oe   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase

      // A direct L load still folds in a flip requested on the same capture edge.
      if (l_load) begin
        fl <= l_data ^ flip;
      end else if (flip) begin
        fl <= ~fl;
      end

      // Overflow set beats a simultaneous clear.
      if (capture && fv_in) begin
        fv <= 1'b1;
      end else if (v_clr) begin
        fv <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: two instances (SETTLE=2 and SETTLE=0) share the inputs and are checked
// against a timeline model of each op's start edge.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        nreset, start, fv_in, nfltadd_in, l_load, l_data, v_clr;
  logic [15:0] y_in;

  logic [15:0] ibus_out_a, ibus_out_b;
  logic        ibus_oe_a, ac_we_a, fl_a, fv_a, busy_a, done_a;
  logic        ibus_oe_b, ac_we_b, fl_b, fv_b, busy_b, done_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(16), .SETTLE(2)) dut_a (
    .clk(clk), .nreset(nreset), .start(start), .y_in(y_in), .fv_in(fv_in),
    .nfltadd_in(nfltadd_in), .l_load(l_load), .l_data(l_data), .v_clr(v_clr),
    .ibus_out(ibus_out_a), .ibus_oe(ibus_oe_a), .ac_we(ac_we_a), .fl(fl_a),
    .fv(fv_a), .busy(busy_a), .done(done_a)
  );

  alu_result_stage #(.WIDTH(16), .SETTLE(0)) dut_b (
    .clk(clk), .nreset(nreset), .start(start), .y_in(y_in), .fv_in(fv_in),
    .nfltadd_in(nfltadd_in), .l_load(l_load), .l_data(l_data), .v_clr(v_clr),
    .ibus_out(ibus_out_b), .ibus_oe(ibus_oe_b), .ac_we(ac_we_b), .fl(fl_b),
    .fv(fv_b), .busy(busy_b), .done(done_b)
  );

  logic [21:0] obs [2];
  assign obs[0] = {ibus_out_a, ibus_oe_a, ac_we_a, done_a, busy_a, fl_a, fv_a};
  assign obs[1] = {ibus_out_b, ibus_oe_b, ac_we_b, done_b, busy_b, fl_b, fv_b};

  // Model: an op is described only by the edge it started on; phase = edges since then.
  localparam int SS [2] = '{2, 0};
  bit          act [2];
  int          t0  [2];
  bit          mfl [2];
  bit          mfv [2];
  logic [15:0] mres [2];
  int          edge_n = 0;
  int          last_edge = 0;

  function automatic logic [21:0] expected(int i);
    int ph;
    bit oe, we;
    ph = last_edge - t0[i];
    oe = act[i] && (ph == SS[i] + 1 || ph == SS[i] + 2);
    we = act[i] && (ph == SS[i] + 2);
    return {mres[i], oe, we, we, act[i], mfl[i], mfv[i]};
  endfunction

  task automatic step();
    int ph;
    bit cap;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (nreset) begin
        act[i] = 0; mfl[i] = 0; mfv[i] = 0; mres[i] = '0;
      end else begin
        ph  = edge_n - t0[i];
        cap = act[i] && (ph == SS[i] + 1);
        if (l_load) mfl[i] = l_data ^ (cap & ~nfltadd_in);
        else if (cap && !nfltadd_in) mfl[i] = ~mfl[i];
        if (cap && fv_in) mfv[i] = 1;
        else if (v_clr) mfv[i] = 0;
        if (cap) mres[i] = y_in;
        if (act[i] && ph == SS[i] + 3) act[i] = 0;
        else if (!act[i] && start) begin
          act[i] = 1; t0[i] = edge_n;
        end
      end
    end
    last_edge = edge_n;
    edge_n++;
    #1;
    if (ac_we_a === 1'b1) $display("txn SETTLE=2 edge %0d result %h fl %b fv %b", last_edge, ibus_out_a, fl_a, fv_a);
    if (ac_we_b === 1'b1) $display("txn SETTLE=0 edge %0d result %h fl %b fv %b", last_edge, ibus_out_b, fl_b, fv_b);
  endtask

  task automatic idle_inputs();
    start = 0; fv_in = 0; nfltadd_in = 1; l_load = 0; l_data = 0; v_clr = 0; y_in = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nreset = 1;
    step();
    step();
    nreset = 0;
  endtask

  // One op on both instances with operands held; returns after dut_a is back in IDLE.
  task automatic run_op(input logic [15:0] y, input bit fvi, input bit nfl);
    int n;
    y_in = y; fv_in = fvi; nfltadd_in = nfl; start = 1;
    step();
    start = 0;
    n = 0;
    while (ac_we_a !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL run_op_timeout: ac_we never seen after %0d cycles, required within 20", n);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    nreset = 1;
    idle_inputs();
    step();
    step();
    vectors++;
    if (obs[0] !== 22'd0 || obs[1] !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_state: got a=%h b=%h required 000000", obs[0], obs[1]);
    end
    nreset = 0;
  endtask

  task automatic test_latency();
    do_reset();
    y_in = 16'hDEAD; fv_in = 0; nfltadd_in = 1; start = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) start = 0;
      vectors++;
      if (ac_we_a !== (i == 4) || ac_we_b !== (i == 2)) begin
        miscompares++;
        $display("FAIL latency_edge%0d: ac_we a=%b b=%b required a=%b b=%b", i, ac_we_a, ac_we_b, i == 4, i == 2);
      end
      if (i == 4) begin
        vectors++;
        if (ibus_out_a !== 16'hDEAD || fl_a !== 1'b0 || fv_a !== 1'b0 || ibus_oe_a !== 1'b1) begin
          miscompares++;
          $display("FAIL latency_result: ibus=%h oe=%b fl=%b fv=%b required DEAD 1 0 0", ibus_out_a, ibus_oe_a, fl_a, fv_a);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_link_toggle();
    do_reset();
    run_op(16'h1111, 0, 0);
    vectors++;
    if (fl_a !== 1'b1) begin
      miscompares++;
      $display("FAIL link_first: fl=%b required 1", fl_a);
    end
    run_op(16'h2222, 0, 0);
    vectors++;
    if (fl_a !== 1'b0 || ibus_out_a !== 16'h2222) begin
      miscompares++;
      $display("FAIL link_second: fl=%b ibus=%h required 0 2222", fl_a, ibus_out_a);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    run_op(16'h0F0F, 1, 1);
    vectors++;
    if (fv_a !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_set: fv=%b required 1", fv_a);
    end
    run_op(16'h00F0, 0, 1);
    vectors++;
    if (fv_a !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_sticky: fv=%b required 1", fv_a);
    end
    v_clr = 1;
    step();
    v_clr = 0;
    vectors++;
    if (fv_a !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clear: fv=%b required 0", fv_a);
    end
    // v_clr held through the dut_a capture edge (edge 3) together with fv_in=1.
    start = 1;
    step();
    start = 0; v_clr = 1; fv_in = 1;
    step();
    step();
    step();
    v_clr = 0;
    vectors++;
    if (fv_a !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_set_wins: fv=%b required 1", fv_a);
    end
    for (int i = 0; i < 3; i++) step();
    idle_inputs();
  endtask

  task automatic test_start_held();
    do_reset();
    y_in = 16'h5A5A;
    start = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 9) start = 0;
      vectors++;
      if (ac_we_a !== (i == 4 || i == 10) || busy_a !== !(i == 5 || i >= 11) ||
          ac_we_b !== (i == 2 || i == 6 || i == 10) || busy_b !== !(i == 3 || i == 7 || i >= 11)) begin
        miscompares++;
        $display("FAIL start_held_edge%0d: a we/busy=%b%b b we/busy=%b%b", i, ac_we_a, busy_a, ac_we_b, busy_b);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    y_in = 16'h1234; fv_in = 1; nfltadd_in = 0; start = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      start = 0;
    end
    vectors++;
    if (ibus_out_a !== 16'h1234 || ibus_oe_a !== 1'b1 || ac_we_a !== 1'b0 || fl_a !== 1'b1 || fv_a !== 1'b1) begin
      miscompares++;
      $display("FAIL drive_phase: ibus=%h oe=%b we=%b fl=%b fv=%b required 1234 1 0 1 1", ibus_out_a, ibus_oe_a, ac_we_a, fl_a, fv_a);
    end
    nreset = 1;
    step();
    nreset = 0;
    idle_inputs();
    vectors++;
    if (obs[0] !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_mid_op: got %h required 000000", obs[0]);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (ac_we_a !== 1'b0 || busy_a !== 1'b0) begin
        miscompares++;
        $display("FAIL aborted_op_cycle%0d: we=%b busy=%b required 0 0", i, ac_we_a, busy_a);
      end
    end
  endtask

  task automatic test_l_load_capture();
    do_reset();
    y_in = 16'hBEEF; nfltadd_in = 0; start = 1;
    step();
    start = 0;
    step();
    step();
    l_load = 1; l_data = 1;
    step();
    l_load = 0; l_data = 0;
    vectors++;
    if (fl_a !== 1'b0 || fl_b !== 1'b1) begin
      miscompares++;
      $display("FAIL l_load_capture: fl a=%b b=%b required a=0 b=1", fl_a, fl_b);
    end
    for (int i = 0; i < 3; i++) step();
    idle_inputs();
  endtask

  task automatic test_random();
    logic [21:0] e;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      nreset     = ($urandom_range(0, 99) < 2);
      start      = ($urandom_range(0, 99) < 40);
      y_in       = 16'($urandom);
      fv_in      = ($urandom_range(0, 3) == 0);
      nfltadd_in = ($urandom_range(0, 2) != 0);
      l_load     = ($urandom_range(0, 9) == 0);
      l_data     = 1'($urandom);
      v_clr      = ($urandom_range(0, 9) == 0);
      step();
      for (int i = 0; i < 2; i++) begin
        e = expected(i);
        vectors++;
        if (obs[i] !== e) begin
          miscompares++;
          $display("FAIL random_s%0d_cycle%0d: got %h required %h", SS[i], c, obs[i], e);
        end
      end
    end
    nreset = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    nreset = 1;
    test_reset();
    test_latency();
    test_link_toggle();
    test_overflow();
    test_start_held();
    test_reset_mid_op();
    test_l_load_capture();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
